// File: rtl/mem_access_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_if
//  Description : Request/acknowledge data-memory port between the MEM-stage
//                access controller (master) and a variable-latency memory
//                (slave).
//                  mem_req   - request, held until ack or abort
//                  mem_we    - 1 = write, 0 = read; valid while mem_req
//                  mem_addr  - byte address of the access
//                  mem_wdata - store data
//                  mem_ack   - single-cycle completion pulse from memory
//                  mem_rdata - read data, valid with mem_ack
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Sequences MEM-stage data-memory accesses over a req/ack port.
//                Freezes the front of the pipeline while an access is in
//                flight, bubbles MEM/WB during the freeze, returns load data
//                and flags illegal requests and bus timeouts.
//  Ports       : clk, rst           - clock, asynchronous active-high reset
//                MemRead3/MemWrite3 - EX/MEM load / store request
//                Addr3/Wdata3       - EX/MEM byte address / store data
//                bus (master)       - memory req/ack port
//                Data_out           - load result to MEM/WB
//                stall, wb_bubble   - pipeline freeze / MEM/WB control squash
//                bus_err, err_clr   - sticky error flag and its clear
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        MemRead3,
    input  wire logic        MemWrite3,
    input  wire logic [31:0] Addr3,
    input  wire logic [31:0] Wdata3,
    mem_access_ctrl_if.master bus,
    output logic      [31:0] Data_out,
    output logic             stall,
    output logic             wb_bubble,
    output logic             bus_err,
    input  wire logic        err_clr
);

    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_req;
    logic             r_mem_we;
    logic [31:0]      r_mem_addr;
    logic [31:0]      r_mem_wdata;
    logic [31:0]      r_data_out;
    logic             r_bus_err;

    logic             w_acc;
    logic             w_illegal;
    logic             w_start;
    logic             w_complete;
    logic             w_timeout;
    logic             w_err_set;

    assign w_acc     = MemRead3 ^ MemWrite3;
    assign w_illegal = MemRead3 & MemWrite3;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        w_err_set  = 1'b0;
        stall      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc) begin
                    w_start = 1'b1;
                    w_next  = S_ACCESS;
                end
                // Simultaneous load+store is rejected without stalling.
                w_err_set = w_illegal;
                stall     = w_acc;
            end
            S_ACCESS: begin
                stall = 1'b1;
                // An ack arriving in the final allowed cycle beats the timeout.
                if (bus.mem_ack) begin
                    w_complete = 1'b1;
                    w_next     = S_DONE;
                end else if (r_cnt == c_TIMEOUT_LAST) begin
                    w_timeout = 1'b1;
                    w_err_set = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                // One released cycle lets the instruction leave EX/MEM
                // before anything new is decoded.
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Keep the pipeline control quiet while reset is held, even if a
        // request is still presented on the EX/MEM inputs.
        if (rst) begin
            stall = 1'b0;
        end
    end

    assign wb_bubble = stall;

    // ------------------------------------------------------------------
    // Access datapath, wait counter and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_data_out  <= 32'd0;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_mem_addr  <= Addr3;
                r_mem_wdata <= Wdata3;
                r_mem_we    <= MemWrite3;
                r_mem_req   <= 1'b1;
                r_cnt       <= '0;
            end else if (r_state == S_ACCESS && !bus.mem_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_complete) begin
                r_mem_req <= 1'b0;
                if (!r_mem_we) begin
                    r_data_out <= bus.mem_rdata;
                end
            end

            if (w_timeout) begin
                r_mem_req  <= 1'b0;
                r_data_out <= 32'd0;
            end

            // A new error event takes priority over a clear request.
            if (w_err_set) begin
                r_bus_err <= 1'b1;
            end else if (err_clr) begin
                r_bus_err <= 1'b0;
            end
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign Data_out      = r_data_out;
    assign bus_err       = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Directed self-checking bench for mem_access_ctrl. Expected
//                completion results are queued when an access is launched
//                and popped when the controller reaches its release cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        MemRead3 = 1'b0;
    logic        MemWrite3 = 1'b0;
    logic [31:0] Addr3 = 32'd0;
    logic [31:0] Wdata3 = 32'd0;
    logic [31:0] Data_out;
    logic        stall;
    logic        wb_bubble;
    logic        bus_err;
    logic        err_clr = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(
        .TIMEOUT (15),
        .CNT_W   (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead3  (MemRead3),
        .MemWrite3 (MemWrite3),
        .Addr3     (Addr3),
        .Wdata3    (Wdata3),
        .bus       (bus),
        .Data_out  (Data_out),
        .stall     (stall),
        .wb_bubble (wb_bubble),
        .bus_err   (bus_err),
        .err_clr   (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access: ack_n = ACCESS cycle carrying the ack (0 = never acked).
    task automatic run_access(input logic rd, input logic wr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input int ack_n, input logic [31:0] rdata,
                              input logic [31:0] exp_data, input logic exp_err);
        exp_t e;
        int   n_stall;
        n_stall = (ack_n > 0) ? ack_n + 1 : 16;
        e.data  = exp_data;
        e.err   = exp_err;
        sb.push_back(e);
        MemRead3  = rd;
        MemWrite3 = wr;
        Addr3     = addr;
        Wdata3    = wdata;
        for (int cyc = 0; cyc <= n_stall; cyc++) begin
            bus.mem_ack   = (ack_n > 0 && cyc == ack_n);
            bus.mem_rdata = bus.mem_ack ? rdata : 32'hDEAD_BEEF;
            @(negedge clk);
            chk("stall", {31'd0, stall}, {31'd0, cyc < n_stall});
            chk("wb_bubble", {31'd0, wb_bubble}, {31'd0, cyc < n_stall});
            chk("mem_req", {31'd0, bus.mem_req}, {31'd0, (cyc >= 1 && cyc < n_stall)});
            if (cyc >= 1 && cyc < n_stall) begin
                chk("mem_addr", bus.mem_addr, addr);
                chk("mem_wdata", bus.mem_wdata, wdata);
                chk("mem_we", {31'd0, bus.mem_we}, {31'd0, wr});
            end
            if (cyc == n_stall) begin
                e = sb.pop_front();
                chk("Data_out", Data_out, e.data);
                chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
            end
            @(posedge clk);
            #1;
        end
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
    endtask

    task automatic idle_cycles(input int n);
        MemRead3  = 1'b0;
        MemWrite3 = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_stall", {31'd0, stall}, 32'd0);
            chk("idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_Data_out", Data_out, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // 1: zero-wait load
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'h1234_5678, 32'h1234_5678, 1'b0);
        idle_cycles(1);

        // 2: store acked in third ACCESS cycle, Data_out untouched
        run_access(1'b0, 1'b1, 32'h200, 32'hCAFE_F00D, 3, 32'h5555_AAAA, 32'h1234_5678, 1'b0);
        idle_cycles(1);

        // 3: load never acked -> timeout, then clear the error
        run_access(1'b1, 1'b0, 32'h300, 32'h0, 0, 32'h0, 32'h0, 1'b1);
        MemRead3 = 1'b0;
        err_clr  = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        chk("err_clr", {31'd0, bus_err}, 32'd0);

        // 4: ack in the last allowed cycle wins over the timeout
        run_access(1'b1, 1'b0, 32'h304, 32'h0, 15, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0);

        // 5: back-to-back loads
        run_access(1'b1, 1'b0, 32'h400, 32'h0, 2, 32'h1111_1111, 32'h1111_1111, 1'b0);
        run_access(1'b1, 1'b0, 32'h404, 32'h0, 1, 32'h2222_2222, 32'h2222_2222, 1'b0);
        idle_cycles(1);

        // 6: illegal load+store with stray ack and simultaneous clear
        MemRead3      = 1'b1;
        MemWrite3     = 1'b1;
        err_clr       = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("illegal_stall", {31'd0, stall}, 32'd0);
        chk("illegal_bubble", {31'd0, wb_bubble}, 32'd0);
        chk("illegal_mem_req", {31'd0, bus.mem_req}, 32'd0);
        @(posedge clk);
        #1;
        err_clr       = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
        chk("illegal_bus_err", {31'd0, bus_err}, 32'd1);
        chk("stray_ack_Data_out", Data_out, 32'h2222_2222);
        idle_cycles(1);
        chk("bus_err_sticky", {31'd0, bus_err}, 32'd1);

        // Reset asserted in the middle of an access
        MemRead3 = 1'b1;
        Addr3    = 32'h500;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_mem_req", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("arst_mem_addr", bus.mem_addr, 32'd0);
        chk("arst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("arst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("arst_Data_out", Data_out, 32'd0);
        chk("arst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        chk("arst_bubble", {31'd0, wb_bubble}, 32'd0);
        MemRead3 = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(1);

        // Controller is back in IDLE and serves a fresh load
        run_access(1'b1, 1'b0, 32'h600, 32'h0, 1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0);
        idle_cycles(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
